// File: rtl/sprite_compositor.sv
// Purpose : N-channel sprite compositor; per-pixel window hit test, ROM address
//           generation, priority mux over opaque sprites, per-frame collision flags.
// Latency : DrawX/DrawY -> Red/Green/Blue is ROM_LAT+1 cycles; one pixel per cycle.
// Backpressure: none; the pixel stream never stalls.
//
// Ports:
//   Clk, Reset           pixel clock, synchronous active-high reset
//   blank, frame_start   1 = active display; one-cycle pulse in vertical blanking
//   DrawX, DrawY         current pixel coordinate
//   spr_en/x/y/w/h       sprite attributes, flattened, sprite i at [i*COORD_W +: COORD_W]
//   bg_R/G/B             background color, same timing as DrawX
//   rom_addr, rom_data   per-channel ROM read port, data ROM_LAT cycles after address
//   Red/Green/Blue       registered output color
//   collide              per-sprite collision flags for the previous frame
//
// Optional feature: define SPRITE_TRANSPARENCY_EN to treat KEY-colored ROM pixels as
// transparent (they fall through and never count toward collisions).

module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          COORD_W     = 10,
    parameter int          ADDR_W      = 19,
    parameter int          ROM_LAT     = 1,
    parameter logic [23:0] KEY         = 24'hFF00FF
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           blank,
    input  logic                           frame_start,
    input  logic [COORD_W-1:0]             DrawX,
    input  logic [COORD_W-1:0]             DrawY,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_w,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_h,
    input  logic [7:0]                     bg_R,
    input  logic [7:0]                     bg_G,
    input  logic [7:0]                     bg_B,
    output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
    input  logic [NUM_SPRITES*24-1:0]      rom_data,
    output logic [7:0]                     Red,
    output logic [7:0]                     Green,
    output logic [7:0]                     Blue,
    output logic [NUM_SPRITES-1:0]         collide
);

    // Shadow copies of the sprite attributes, loaded only on frame_start so a
    // sprite never moves partway through a frame.
    logic [NUM_SPRITES-1:0]         en_q;
    logic [NUM_SPRITES*COORD_W-1:0] x_q, y_q, w_q, h_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            en_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
            w_q  <= '0;
            h_q  <= '0;
        end else if (frame_start) begin
            en_q <= spr_en;
            x_q  <= spr_x;
            y_q  <= spr_y;
            w_q  <= spr_w;
            h_q  <= spr_h;
        end
    end

    // Per-channel hit test and address. Offsets are unsigned modulo 2^COORD_W,
    // so pixels left of / above a sprite wrap to large values and miss.
    logic [NUM_SPRITES-1:0] hit;

    genvar g;
    for (g = 0; g < NUM_SPRITES; g++) begin : g_ch
        logic [COORD_W-1:0] dx, dy, w, h;
        assign w  = w_q[g*COORD_W +: COORD_W];
        assign h  = h_q[g*COORD_W +: COORD_W];
        assign dx = DrawX - x_q[g*COORD_W +: COORD_W];
        assign dy = DrawY - y_q[g*COORD_W +: COORD_W];
        assign hit[g] = en_q[g] & (dx < w) & (dy < h);
        assign rom_addr[g*ADDR_W +: ADDR_W] = ADDR_W'(dx) + ADDR_W'(w) * ADDR_W'(dy);
    end

    // Delay line aligning hit/blank/background with the ROM data.
    logic [NUM_SPRITES-1:0] hit_dly_q   [ROM_LAT];
    logic                   blank_dly_q [ROM_LAT];
    logic [23:0]            bg_dly_q    [ROM_LAT];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < ROM_LAT; s++) begin
                hit_dly_q[s]   <= '0;
                blank_dly_q[s] <= 1'b0;
                bg_dly_q[s]    <= '0;
            end
        end else begin
            hit_dly_q[0]   <= hit;
            blank_dly_q[0] <= blank;
            bg_dly_q[0]    <= {bg_R, bg_G, bg_B};
            for (int s = 1; s < ROM_LAT; s++) begin
                hit_dly_q[s]   <= hit_dly_q[s-1];
                blank_dly_q[s] <= blank_dly_q[s-1];
                bg_dly_q[s]    <= bg_dly_q[s-1];
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit_al;
    logic                   blank_al;
    logic [23:0]            bg_al;
    assign hit_al   = hit_dly_q[ROM_LAT-1];
    assign blank_al = blank_dly_q[ROM_LAT-1];
    assign bg_al    = bg_dly_q[ROM_LAT-1];

    logic [NUM_SPRITES-1:0] opaque;
`ifdef SPRITE_TRANSPARENCY_EN
    for (g = 0; g < NUM_SPRITES; g++) begin : g_opq
        assign opaque[g] = hit_al[g] & (rom_data[g*24 +: 24] != KEY);
    end
`else
    logic unused_key;
    assign unused_key = ^KEY;
    assign opaque     = hit_al;
`endif

    // Priority mux: scan from lowest priority upward so index 0 wins last.
    logic [23:0]            color_d, color_q;
    logic [NUM_SPRITES-1:0] acc_d, acc_q, collide_q;

    always_comb begin
        color_d = bg_al;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) color_d = rom_data[i*24 +: 24];
        end
        if (!blank_al) color_d = '0;

        acc_d = acc_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (blank_al && opaque[i] && (|(opaque & ~(NUM_SPRITES'(1) << i))))
                acc_d[i] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_q   <= '0;
            acc_q     <= '0;
            collide_q <= '0;
        end else begin
            color_q <= color_d;
            if (frame_start) begin
                // Report includes this cycle's contribution, then start afresh.
                collide_q <= acc_d;
                acc_q     <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    assign Red     = color_q[23:16];
    assign Green   = color_q[15:8];
    assign Blue    = color_q[7:0];
    assign collide = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

    localparam int NS  = 4;
    localparam int CW  = 10;
    localparam int AW  = 19;
    localparam int RL  = 1;
    localparam int LAT = RL + 1;
    localparam logic [23:0] KEYC = 24'hFF00FF;
`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Reset, blank, frame_start;
    logic [CW-1:0]   DrawX, DrawY;
    logic [NS-1:0]   spr_en;
    logic [NS*CW-1:0] spr_x, spr_y, spr_w, spr_h;
    logic [7:0]      bg_R, bg_G, bg_B;
    logic [NS*AW-1:0] rom_addr;
    logic [NS*24-1:0] rom_data = '0;
    logic [7:0]      Red, Green, Blue;
    logic [NS-1:0]   collide;

    sprite_compositor #(.NUM_SPRITES(NS), .COORD_W(CW), .ADDR_W(AW), .ROM_LAT(RL), .KEY(KEYC)) dut (
        .Clk(Clk), .Reset(Reset), .blank(blank), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .spr_en(spr_en),
        .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
        .bg_R(bg_R), .bg_G(bg_G), .bg_B(bg_B),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .Red(Red), .Green(Green), .Blue(Blue), .collide(collide)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ROM image: red byte identifies the channel, green/blue carry the address;
    // one optional (channel, address) location returns the key color.
    int key_ch = -1;
    int key_addr = 0;

    function automatic logic [23:0] rom_fn(input int ch, input int addr);
        if (ch == key_ch && addr == key_addr) return KEYC;
        return {8'(16 + 32 * ch), 16'(addr)};
    endfunction

    always @(posedge Clk) begin
        for (int c = 0; c < NS; c++)
            rom_data[c*24 +: 24] <= rom_fn(c, int'(rom_addr[c*AW +: AW]));
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Programmed attributes (what is on the inputs) and the model's shadow.
    bit c_en[NS];
    int c_x[NS], c_y[NS], c_w[NS], c_h[NS];
    bit m_en[NS];
    int m_x[NS], m_y[NS], m_w[NS], m_h[NS];
    logic [NS-1:0] m_acc, m_coll;
    logic [23:0] exp_q[$];

    task automatic set_spr(input int i, input bit en, input int x, input int y, input int w, input int h);
        c_en[i] = en; c_x[i] = x; c_y[i] = y; c_w[i] = w; c_h[i] = h;
        spr_en[i] = en;
        spr_x[i*CW +: CW] = CW'(x);
        spr_y[i*CW +: CW] = CW'(y);
        spr_w[i*CW +: CW] = CW'(w);
        spr_h[i*CW +: CW] = CW'(h);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0;
        end
        m_acc = '0; m_coll = '0;
    endtask

    // Reference pixel: straight from the window/priority rules.
    task automatic model_pix(input int x, input int y, input bit blk, input logic [23:0] bg,
                             output logic [23:0] col, output logic [NS-1:0] opq);
        bit found = 0;
        col = bg;
        opq = '0;
        for (int i = 0; i < NS; i++) begin
            int dx = (x - m_x[i]) & 1023;
            int dy = (y - m_y[i]) & 1023;
            int addr = (dx + m_w[i] * dy) & ((1 << AW) - 1);
            logic [23:0] d = rom_fn(i, addr);
            bit h = m_en[i] && dx < m_w[i] && dy < m_h[i];
            if (h && (!TRANSP || d != KEYC)) begin
                opq[i] = 1'b1;
                if (!found) begin col = d; found = 1; end
            end
        end
        if (!blk) col = '0;
    endtask

    // One pixel per call, entered and left at a falling edge. The output for the
    // pixel driven LAT calls earlier is compared first.
    task automatic step(input int x, input int y, input bit blk, input bit fs,
                        input logic [23:0] bg, input bit use_exp, input logic [23:0] e);
        logic [23:0] mc;
        logic [NS-1:0] mo;
        if (exp_q.size() == LAT) chk("pixel", {8'h0, Red, Green, Blue}, {8'h0, exp_q.pop_front()});
        DrawX = CW'(x); DrawY = CW'(y); blank = blk; frame_start = fs;
        {bg_R, bg_G, bg_B} = bg;
        model_pix(x, y, blk, bg, mc, mo);
        exp_q.push_back(use_exp ? e : mc);
        if (fs) begin
            m_coll = m_acc; m_acc = '0;
            for (int i = 0; i < NS; i++) begin
                m_en[i] = c_en[i]; m_x[i] = c_x[i]; m_y[i] = c_y[i]; m_w[i] = c_w[i]; m_h[i] = c_h[i];
            end
        end
        if (blk && $countones(mo) >= 2) m_acc = m_acc | mo;
        @(negedge Clk);
    endtask

    task automatic blank_px(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 24'h123456, 0, 24'h0);
    endtask

    task automatic frame();
        blank_px(LAT + 1);
        step(0, 0, 0, 1, 24'h0, 0, 24'h0);
        chk("collide", {28'h0, collide}, {28'h0, m_coll});
        blank_px(1);
    endtask

    typedef struct {
        int x; int y; bit blk; logic [23:0] bg; logic [23:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic do_reset_midline();
        Reset = 1; frame_start = 0; blank = 0;
        exp_q.delete();
        model_reset();
        @(negedge Clk);
        chk("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        chk("reset_collide", {28'h0, collide}, 32'h0);
        Reset = 0;
    endtask

    initial begin
        Reset = 1; blank = 0; frame_start = 0; DrawX = '0; DrawY = '0;
        spr_en = '0; spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0;
        bg_R = 0; bg_G = 0; bg_B = 0;
        for (int i = 0; i < NS; i++) set_spr(i, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        chk("rst_collide", {28'h0, collide}, 32'h0);
        Reset = 0;

        // Fixed-vector table.
        tbl[0]  = '{110, 110, 1, 24'hB00101, 24'h1000AA};
        tbl[1]  = '{120, 120, 1, 24'hB00202, 24'h3000CC};
        tbl[2]  = '{100, 100, 1, 24'hB00303, 24'h100000};
        tbl[3]  = '{115, 115, 1, 24'hB00404, 24'h1000FF};
        tbl[4]  = '{116, 100, 1, 24'hB00505, 24'hB00505};
        tbl[5]  = '{15,  200, 1, 24'hB00606, 24'h50000F};
        tbl[6]  = '{16,  200, 1, 24'hB00707, 24'hB00707};
        tbl[7]  = '{3,   300, 1, 24'hB00808, 24'hB00808};
        tbl[8]  = '{5,   301, 1, 24'hB00909, 24'h700010};
        tbl[9]  = '{110, 110, 0, 24'hB00A0A, 24'h000000};
        tbl[10] = '{123, 123, 1, 24'hB00B0B, 24'h3000FF};
        tbl[11] = '{124, 108, 1, 24'hB00C0C, 24'hB00C0C};
        set_spr(0, 1, 100, 100, 16, 16);
        set_spr(1, 1, 108, 108, 16, 16);
        set_spr(2, 1, 0, 200, 16, 16);
        set_spr(3, 1, 5, 300, 16, 16);
        frame();
        for (int k = 0; k < 12; k++) step(tbl[k].x, tbl[k].y, tbl[k].blk, 0, tbl[k].bg, 1, tbl[k].exp);
        frame();

        // Transparency at the overlap pixel of sprites 0 and 1.
        set_spr(2, 0, 0, 0, 0, 0);
        set_spr(3, 0, 0, 0, 0, 0);
        key_ch = 0; key_addr = 170;
        frame();
        step(110, 110, 1, 0, 24'hC0C0C0, 1, TRANSP ? 24'h300022 : 24'hFF00FF);
        frame();
        chk("transp_collide", {28'h0, collide}, TRANSP ? 32'h0 : 32'h3);
        key_ch = -1;

        // Tear-free move of sprite 0.
        set_spr(1, 0, 0, 0, 0, 0);
        frame();
        step(100, 100, 1, 0, 24'h0A0B0C, 1, 24'h100000);
        set_spr(0, 1, 200, 100, 16, 16);
        step(100, 100, 1, 0, 24'h0A0B0C, 1, 24'h100000);
        step(200, 100, 1, 0, 24'h0A0B0C, 1, 24'h0A0B0C);
        frame();
        step(200, 100, 1, 0, 24'h0A0B0C, 1, 24'h100000);
        step(100, 100, 1, 0, 24'h0A0B0C, 1, 24'h0A0B0C);

        // Collision reporting for sprites 2 and 3 in one frame only.
        set_spr(0, 0, 0, 0, 0, 0);
        set_spr(2, 1, 300, 300, 8, 8);
        set_spr(3, 1, 304, 304, 8, 8);
        frame();
        step(305, 305, 1, 0, 24'h010203, 1, 24'h50002D);
        frame();
        chk("coll_frameN", {28'h0, collide}, 32'hC);
        step(300, 300, 1, 0, 24'h010203, 1, 24'h500000);
        frame();
        chk("coll_frameN1", {28'h0, collide}, 32'h0);

        // Reset in the middle of a line.
        set_spr(0, 1, 100, 100, 16, 16);
        frame();
        step(105, 100, 1, 0, 24'h445566, 1, 24'h500005 - 24'h400000);
        step(106, 100, 1, 0, 24'h445566, 1, 24'h100006);
        do_reset_midline();
        step(105, 100, 1, 0, 24'h445566, 1, 24'h445566);
        chk("reset_fill", {8'h0, Red, Green, Blue}, 32'h0);
        step(106, 100, 1, 0, 24'h778899, 1, 24'h778899);
        step(107, 100, 1, 0, 24'h778899, 0, 24'h0);
        frame();
        step(105, 100, 1, 0, 24'h445566, 1, 24'h100005);

        // Randomised configurations against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NS; i++)
                set_spr(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 63), $urandom_range(0, 63),
                        $urandom_range(1, 40), $urandom_range(1, 40));
            key_ch = $urandom_range(0, 3);
            key_addr = $urandom_range(0, 100);
            frame();
            for (int k = 0; k < 300; k++) begin
                int x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 100);
                int y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 100);
                step(x, y, 1'($urandom_range(0, 4) != 0), 0, 24'($urandom), 0, 24'h0);
            end
            frame();
        end
        key_ch = -1;
        blank_px(LAT);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
